// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, FSM encoding
// and the fault check applied to an incoming request.
package load_store_unit_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        LSU_IDLE   = 3'd0,
        LSU_ACCESS = 3'd1,
        LSU_RMW_RD = 3'd2,
        LSU_RMW_WR = 3'd3,
        LSU_DONE   = 3'd4
    } lsu_state_t;

    // Unsigned widths exist only for loads; every other code is illegal.
    function automatic logic lsu_fault(input logic is_load, input logic [2:0] funct3,
                                       input logic [1:0] addr_lo);
        logic fault;
        fault = 1'b0;
        case (funct3)
            F3_B:    fault = 1'b0;
            F3_H:    fault = addr_lo[0];
            F3_W:    fault = (addr_lo != 2'b00);
            F3_BU:   fault = !is_load;
            F3_HU:   fault = !is_load || addr_lo[0];
            default: fault = 1'b1;
        endcase
        return fault;
    endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Lane logic: extracts and extends the addressed byte/halfword of a read word,
// and merges store data into a read word for the read-modify-write path.
module load_store_unit_align
    import load_store_unit_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    input  logic [15:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  byte_val;
    logic [15:0] half_val;

    always_comb begin
        byte_val = rdata[{addr_lo, 3'b000} +: 8];
        half_val = rdata[{addr_lo[1], 4'b0000} +: 16];
        case (funct3[1:0])
            2'b00:   load_data = funct3[2] ? {24'b0, byte_val} : {{24{byte_val[7]}}, byte_val};
            2'b01:   load_data = funct3[2] ? {16'b0, half_val} : {{16{half_val[15]}}, half_val};
            default: load_data = rdata;
        endcase
    end

    // funct3[0] selects halfword stores; otherwise a single byte lane is replaced.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic       lane_sel;
            logic [7:0] store_byte;
            assign lane_sel   = funct3[0] ? (addr_lo[1] == 1'(gi >> 1)) : (addr_lo == 2'(gi));
            assign store_byte = funct3[0] ? wdata[8*(gi%2) +: 8] : wdata[7:0];
            assign merged[8*gi +: 8] = lane_sel ? store_byte : rdata[8*gi +: 8];
        end
    endgenerate

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: word-addressed cache handshake, byte/half
// stores via read-modify-write, extended load data and misalign reporting.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int MEM_AW = 30
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_load,
    input  logic [2:0]        req_funct3,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic [4:0]        req_rd,
    output logic              resp_valid,
    output logic [4:0]        resp_rd,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_wb,
    output logic              resp_misalign,
    output logic              mem_ren,
    output logic              mem_wen,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              mem_stall
);

    lsu_state_t      state_reg, state_next;
    logic            load_reg;
    logic [2:0]      funct3_reg;
    logic [XLEN-1:0] addr_reg;
    logic [XLEN-1:0] wdata_reg;
    logic [4:0]      rd_reg;
    logic [4:0]      resp_rd_reg;
    logic [XLEN-1:0] resp_rdata_reg;
    logic            resp_wb_reg;
    logic            resp_misalign_reg;
    logic            req_fault;
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] merged;

    assign req_fault = lsu_fault(req_load, req_funct3, req_addr[1:0]);

    load_store_unit_align u_align (
        .funct3    (funct3_reg),
        .addr_lo   (addr_reg[1:0]),
        .rdata     (mem_rdata),
        .wdata     (wdata_reg[15:0]),
        .load_data (load_data),
        .merged    (merged)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= LSU_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            LSU_IDLE: begin
                if (req_valid) begin
                    if (req_fault)
                        state_next = LSU_DONE;
                    else if (req_load || req_funct3 == F3_W)
                        state_next = LSU_ACCESS;
                    else
                        state_next = LSU_RMW_RD;
                end
            end
            LSU_ACCESS: if (!mem_stall) state_next = LSU_DONE;
            LSU_RMW_RD: if (!mem_stall) state_next = LSU_RMW_WR;
            LSU_RMW_WR: if (!mem_stall) state_next = LSU_DONE;
            LSU_DONE:   state_next = LSU_IDLE;
            default:    state_next = LSU_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_ren    = 1'b0;
        mem_wen    = 1'b0;
        case (state_reg)
            LSU_IDLE:   req_ready = 1'b1;
            LSU_ACCESS: begin
                mem_ren = load_reg;
                mem_wen = !load_reg;
            end
            LSU_RMW_RD: mem_ren = 1'b1;
            LSU_RMW_WR: mem_wen = 1'b1;
            LSU_DONE:   resp_valid = 1'b1;
            default:    ;
        endcase
    end

    // Result registers load on the edge that enters DONE so they are valid
    // alongside resp_valid; the RMW merge reuses wdata_reg as the write word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            load_reg          <= 1'b0;
            funct3_reg        <= 3'b000;
            addr_reg          <= '0;
            wdata_reg         <= '0;
            rd_reg            <= 5'd0;
            resp_rd_reg       <= 5'd0;
            resp_rdata_reg    <= '0;
            resp_wb_reg       <= 1'b0;
            resp_misalign_reg <= 1'b0;
        end else begin
            case (state_reg)
                LSU_IDLE: begin
                    if (req_valid) begin
                        load_reg   <= req_load;
                        funct3_reg <= req_funct3;
                        addr_reg   <= req_addr;
                        wdata_reg  <= req_wdata;
                        rd_reg     <= req_rd;
                        if (req_fault) begin
                            resp_rd_reg       <= req_rd;
                            resp_rdata_reg    <= '0;
                            resp_wb_reg       <= 1'b0;
                            resp_misalign_reg <= 1'b1;
                        end
                    end
                end
                LSU_ACCESS: begin
                    if (!mem_stall) begin
                        resp_rd_reg       <= rd_reg;
                        resp_rdata_reg    <= load_reg ? load_data : '0;
                        resp_wb_reg       <= load_reg && (rd_reg != 5'd0);
                        resp_misalign_reg <= 1'b0;
                    end
                end
                LSU_RMW_RD: begin
                    if (!mem_stall) wdata_reg <= merged;
                end
                LSU_RMW_WR: begin
                    if (!mem_stall) begin
                        resp_rd_reg       <= rd_reg;
                        resp_rdata_reg    <= '0;
                        resp_wb_reg       <= 1'b0;
                        resp_misalign_reg <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_addr      = addr_reg[XLEN-1:2];
    assign mem_wdata     = wdata_reg;
    assign resp_rd       = resp_rd_reg;
    assign resp_rdata    = resp_rdata_reg;
    assign resp_wb       = resp_wb_reg;
    assign resp_misalign = resp_misalign_reg;

endmodule
